// File: rtl/cdc_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the write port of a CDC FIFO.
// Also sequences flushes: terminate abandons the burst and drives a timed fifoTerminate pulse.
module cdc_wr_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_WIDTH     = 2,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_BEATS    = 16,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            reqLast,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            reqReady,
  input  logic                          fifoReady,
  output logic                          fifoWe,
  output logic [DATA_WIDTH-1:0]         fifoData,
  output logic [ID_WIDTH-1:0]           fifoId,
  input  logic                          terminate,
  output logic                          fifoTerminate,
  output logic                          grantValid,
  output logic                          overrun
);

  localparam int unsigned BEAT_W  = $clog2(MAX_BEATS + 2);
  localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [BEAT_W-1:0]   BEAT_SAT   = BEAT_W'(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0]   BEAT_OVR   = BEAT_W'(MAX_BEATS);
  localparam logic [FLUSH_W-1:0]  FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0] LAST_ID    = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, FLUSH = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic [ID_WIDTH-1:0]    grant_id, rr_ptr, winner, next_ptr;
  logic [2*NUM_REQ-1:0]   rot;
  logic                   any_req, req_g, last_g, xfer;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [FLUSH_W-1:0]     flush_cnt;

  // Winner: first set req at or after rr_ptr, found by rotating a doubled vector
  always_comb begin
    int unsigned off;
    int unsigned sum;
    off     = 0;
    any_req = 1'b0;
    rot     = {req, req} >> rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off     = k;
        any_req = 1'b1;
      end
    end
    sum = int'(rr_ptr) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    winner = ID_WIDTH'(sum);
  end

  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + ID_WIDTH'(1);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (terminate) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        IDLE:    if (any_req) state_nxt = BURST;
        BURST:   if (xfer && last_g) state_nxt = IDLE;
        FLUSH:   if (flush_cnt == '0) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Write-port outputs follow fifoReady/terminate combinationally in the same cycle
  always_comb begin
    fifoData = reqData[DATA_WIDTH-1:0];
    req_g    = 1'b0;
    last_g   = 1'b0;
    reqReady = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        fifoData    = reqData[i*DATA_WIDTH +: DATA_WIDTH];
        req_g       = req[i];
        last_g      = reqLast[i];
        reqReady[i] = (state == BURST) && !terminate && fifoReady;
      end
    end
    fifoId = grant_id;
    xfer   = (state == BURST) && !terminate && req_g && fifoReady;
    fifoWe = xfer;
  end

  assign grantValid    = (state == BURST);
  assign fifoTerminate = (state == FLUSH);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      grant_id  <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      if (xfer && beat_cnt == BEAT_OVR) overrun <= 1'b1;
      if (terminate) begin
        rr_ptr    <= '0;
        flush_cnt <= FLUSH_LOAD;
      end else begin
        case (state)
          IDLE: begin
            if (any_req) begin
              grant_id <= winner;
              beat_cnt <= '0;
            end
          end
          BURST: begin
            if (xfer) begin
              if (beat_cnt != BEAT_SAT) beat_cnt <= beat_cnt + BEAT_W'(1);
              if (last_g) rr_ptr <= next_ptr;
            end
          end
          FLUSH: begin
            if (flush_cnt != '0) flush_cnt <= flush_cnt - FLUSH_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/cdc_wr_arbiter.md
# cdc_wr_arbiter

Round-robin arbiter that shares the single write port of a clock-domain-crossing FIFO among NUM_REQ requesters, with burst locking. A granted requester keeps the port until its last beat, so bursts are never interleaved in the FIFO. The block sits in the write clock domain in front of the CDC FIFO write controller. It also sequences flushes: on `terminate` it abandons the current burst and drives a timed terminate pulse to the FIFO.

## Interface
Parameters:
- NUM_REQ, 4 — number of requesters (2..8)
- ID_WIDTH, 2 — width of grant index; must be ≥ clog2(NUM_REQ)
- DATA_WIDTH, 32 — beat payload width
- MAX_BEATS, 16 — burst length above which `overrun` is flagged
- FLUSH_CYCLES, 4 — length of the `fifoTerminate` pulse; must be ≥ 2 + synchronizer depth of the FIFO

Ports:
- clk  in  1  write-domain clock
- arst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester beat valid
- reqLast  in  NUM_REQ  per-requester last-beat marker, qualified by req
- reqData  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- reqReady  out  NUM_REQ  per-requester beat accepted
- fifoReady  in  1  FIFO not full
- fifoWe  out  1  FIFO write enable
- fifoData  out  DATA_WIDTH  payload of the granted requester
- fifoId  out  ID_WIDTH  index of the granted requester, written alongside the data
- terminate  in  1  synchronous abort/flush request
- fifoTerminate  out  1  terminate to the FIFO write/read controllers
- grantValid  out  1  a burst is currently locked
- overrun  out  1  sticky; set when a burst exceeds MAX_BEATS

## Operation
- FSM states: IDLE, BURST, FLUSH.
- **IDLE**
  - If any `req` bit is set, the winner is the first set bit at or after `rrPtr`, searching upward with modulo NUM_REQ wrap.
  - `grantId` is registered to the winner, `grantValid` goes to 1 and the FSM moves to BURST.
  - `beatCnt` is cleared to 0.
- **BURST** (granted index g)
  - A beat transfers when `req[g]` & `fifoReady`.
  - `reqReady[g]` = `fifoReady`; every other `reqReady` bit is 0.
  - `fifoWe` = `req[g]` & `fifoReady`; `fifoData` = slice g of `reqData`; `fifoId` = g.
  - Each transferred beat increments `beatCnt`, which saturates at MAX_BEATS+1.
  - A beat that transfers while `beatCnt` = MAX_BEATS sets `overrun`. `overrun` clears only on reset.
  - A transferred beat with `reqLast[g]` ends the burst:
    - `rrPtr` ← (g+1) mod NUM_REQ
    - FSM → IDLE, `grantValid` → 0
  - `req[g]` deasserting mid-burst does not release the grant.
- **FLUSH**
  - Entered from any state when `terminate` = 1.
  - `fifoWe` = 0 and all `reqReady` = 0 in the same cycle `terminate` is seen (combinational gate).
  - `grantValid` → 0 and `rrPtr` → 0.
  - `fifoTerminate` = 1 for FLUSH_CYCLES cycles, counted by `flushCnt`. `terminate` still high reloads `flushCnt`, which extends the flush.
  - When `flushCnt` expires: FSM → IDLE, `fifoTerminate` → 0.
- **Reset** (`arst` low, from any state mid-operation)
  - FSM = IDLE; `rrPtr` = 0; `grantValid` = 0; `grantId` = 0; `overrun` = 0; `fifoTerminate` = 0.
  - Combinational outputs in IDLE: `fifoWe` = 0, `reqReady` = 0, `fifoData` = slice 0, `fifoId` = 0.
- Precedence, highest first: reset, `terminate`, end of burst.

## Timing
- Arbitration latency: `req` rising in IDLE at cycle N gives `grantValid` = 1 at N+1. The first beat can transfer at N+1.
- Burst-to-burst gap: exactly one IDLE cycle after the last beat. There is no back-to-back grant.
- Throughput inside a burst: one beat per cycle while `req[g]` and `fifoReady` are both high.
- `fifoReady` low stalls with zero beats lost. `fifoWe` and `reqReady` follow `fifoReady` combinationally in the same cycle.
- `fifoTerminate` rises the cycle after `terminate` is sampled high and lasts FLUSH_CYCLES cycles after `terminate`'s last high cycle.
- No combinational path from `req` to the `grantId` register output.

## Test plan
- **Round robin:** NUM_REQ=4, `req`=4'b1111, every burst 2 beats, `fifoReady`=1 → grant order 0,1,2,3,0; each burst is 2 `fifoWe` cycles followed by 1 idle cycle.
- **Burst lock:** requester 1 sends a 5-beat burst while requester 0 requests continuously → `fifoId`=1 for all 5 beats; requester 0 is granted 2 cycles after beat 5.
- **Backpressure:** `fifoReady` low for 3 cycles in the middle of a 4-beat burst → `fifoWe`=0 and `reqReady`=0 during the stall; exactly 4 writes total, data order preserved.
- **Overrun:** MAX_BEATS=16, 17-beat burst → `overrun` rises on beat 17 and stays high until `arst`.
- **Terminate mid-burst:** `terminate` pulsed for 1 cycle on beat 2 of 4 → `fifoWe`=0 that cycle; `fifoTerminate` high for 4 cycles; the next grant goes to requester 0.
- **Async reset mid-burst:** `arst` low during BURST → `grantValid`, `fifoWe`, `reqReady` and `fifoTerminate` are 0 immediately; after release, arbitration restarts from requester 0.
